// File: rtl/matched_filter_ctrl_pkg.sv
// Shared types and constants for the matched-filter run-time sequencer.
// Saturation codes are derived from the sample width so the detector tracks INBITS.
package matched_filter_ctrl_pkg;

   typedef enum logic [1:0] {
      MODE_RAW   = 2'd0,
      MODE_FILT  = 2'd1,
      MODE_BLANK = 2'd2
   } mode_e;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_THRESH = 2'd2;
   localparam logic [1:0] ADDR_SATCNT = 2'd3;

   localparam int CTRL_MODE_REQ_BIT  = 0;
   localparam int CTRL_AUTO_BYP_BIT  = 1;
   localparam int STATUS_MODE_LSB    = 0;
   localparam int STATUS_ALARM_BIT   = 8;

   localparam logic [31:0] THRESH_RST = 32'hFFFF_FFFF;

   // Largest positive and most negative two's-complement codes of an inbits-wide sample.
   function automatic logic [31:0] sat_code_pos(input int inbits);
      return (32'd1 << (inbits - 1)) - 32'd1;
   endfunction

   function automatic logic [31:0] sat_code_neg(input int inbits);
      return 32'd1 << (inbits - 1);
   endfunction

endpackage

// File: rtl/matched_filter_ctrl_if.sv
// Software register port of the matched-filter sequencer.
// Single-cycle wr/rd strobes, acknowledged one cycle later.
interface matched_filter_ctrl_if;
   logic        reg_wr_i;
   logic        reg_rd_i;
   logic [1:0]  reg_addr_i;
   logic [31:0] reg_wdata_i;
   logic [31:0] reg_rdata_o;
   logic        reg_ack_o;

   modport slave (
      input  reg_wr_i,
      input  reg_rd_i,
      input  reg_addr_i,
      input  reg_wdata_i,
      output reg_rdata_o,
      output reg_ack_o
   );

   modport master (
      output reg_wr_i,
      output reg_rd_i,
      output reg_addr_i,
      output reg_wdata_i,
      input  reg_rdata_o,
      input  reg_ack_o
   );
endinterface

// File: rtl/matched_filter_ctrl_sat_window_counter.sv
// Counts saturated filter samples over free-running 2^WIN_LOG2-cycle windows.
// Exposes the running window total so the alarm compare sees the final-cycle count.
module sat_window_counter
   import matched_filter_ctrl_pkg::*;
#(
   parameter int INBITS   = 12,
   parameter int NSAMP    = 8,
   parameter int WIN_LOG2 = 16
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic [NSAMP*INBITS-1:0] samp_i,
   output logic [31:0]             satcnt_o,
   output logic [31:0]             win_total_o,
   output logic                    win_end_o
);

   localparam int CW = $clog2(NSAMP + 1);
   localparam logic [INBITS-1:0] SAT_POS = INBITS'(sat_code_pos(INBITS));
   localparam logic [INBITS-1:0] SAT_NEG = INBITS'(sat_code_neg(INBITS));

   logic [CW-1:0]       w_nsat;
   logic [32:0]         w_sum;
   logic [31:0]         w_total;
   logic                w_win_end;
   logic [31:0]         r_acc;
   logic [31:0]         r_satcnt;
   logic [WIN_LOG2-1:0] r_win_cnt;

   always_comb begin
      w_nsat = '0;
      for (int i = 0; i < NSAMP; i++) begin
         if (samp_i[i*INBITS +: INBITS] == SAT_POS || samp_i[i*INBITS +: INBITS] == SAT_NEG)
            w_nsat = w_nsat + CW'(1);
      end
   end

   assign w_sum   = {1'b0, r_acc} + 33'(w_nsat);
   assign w_total = w_sum[32] ? 32'hFFFF_FFFF : w_sum[31:0];

   // Down-counter wrapping from 0: it reads 1 on the 2^WIN_LOG2-th cycle after reset.
   assign w_win_end = (r_win_cnt == WIN_LOG2'(1));

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_win_cnt <= '0;
         r_acc     <= '0;
         r_satcnt  <= '0;
      end else begin
         r_win_cnt <= r_win_cnt - WIN_LOG2'(1);
         if (w_win_end) begin
            r_satcnt <= w_total;
            r_acc    <= '0;
         end else begin
            r_acc    <= w_total;
         end
      end
   end

   assign satcnt_o    = r_satcnt;
   assign win_total_o = w_total;
   assign win_end_o   = w_win_end;

endmodule

// File: rtl/matched_filter_ctrl.sv
// Run-time sequencer for the matched filter: raw/filtered output select with
// blanking on mode changes, saturation alarm with optional auto-bypass, register port.
module matched_filter_ctrl
   import matched_filter_ctrl_pkg::*;
#(
   parameter int INBITS    = 12,
   parameter int NSAMP     = 8,
   parameter int FILT_LAT  = 5,
   parameter int BLANK_CYC = 4,
   parameter int WIN_LOG2  = 16
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic [NSAMP*INBITS-1:0] raw_i,
   input  logic [NSAMP*INBITS-1:0] filt_i,
   output logic [NSAMP*INBITS-1:0] data_o,
   output logic [1:0]              mode_o,
   output logic                    alarm_o,
   matched_filter_ctrl_if.slave    reg_if
);

   // state      | meaning
   // MODE_RAW   | output carries latency-matched raw ADC data
   // MODE_FILT  | output carries filter data
   // MODE_BLANK | output zeroed; counting down toward latched r_dest

   localparam int DW  = NSAMP * INBITS;
   localparam int BCW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
   localparam logic [BCW-1:0] BLANK_LOAD   = BCW'(BLANK_CYC - 1);
   // A retarget mid-blank already spends the current cycle blanked.
   localparam logic [BCW-1:0] BLANK_RELOAD = BCW'((BLANK_CYC >= 2) ? BLANK_CYC - 2 : 0);

   mode_e           r_state;
   mode_e           w_state_nxt;
   mode_e           r_dest;
   mode_e           w_dest_nxt;
   mode_e           w_target;
   logic [BCW-1:0]  r_blank_cnt;
   logic [BCW-1:0]  w_blank_cnt_nxt;

   logic [DW-1:0]   r_dly [FILT_LAT];
   logic [DW-1:0]   r_data;

   logic            r_mode_req;
   logic            r_auto_byp;
   logic            r_alarm;
   logic [31:0]     r_thresh;
   logic            r_ack;
   logic [31:0]     r_rdata;
   logic [31:0]     w_rd_val;
   logic            w_wr;
   logic            w_rd;

   logic [31:0]     w_satcnt;
   logic [31:0]     w_win_total;
   logic            w_win_end;

   sat_window_counter #(
      .INBITS   (INBITS),
      .NSAMP    (NSAMP),
      .WIN_LOG2 (WIN_LOG2)
   ) u_sat (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .samp_i      (filt_i),
      .satcnt_o    (w_satcnt),
      .win_total_o (w_win_total),
      .win_end_o   (w_win_end)
   );

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int k = 0; k < FILT_LAT; k++) r_dly[k] <= '0;
      end else begin
         r_dly[0] <= raw_i;
         for (int k = 1; k < FILT_LAT; k++) r_dly[k] <= r_dly[k-1];
      end
   end

   assign w_target = (r_mode_req && !(r_auto_byp && r_alarm)) ? MODE_FILT : MODE_RAW;

   always_comb begin
      w_state_nxt     = r_state;
      w_dest_nxt      = r_dest;
      w_blank_cnt_nxt = r_blank_cnt;
      case (r_state)
         MODE_RAW, MODE_FILT: begin
            if (w_target != r_state) begin
               w_state_nxt     = MODE_BLANK;
               w_dest_nxt      = w_target;
               w_blank_cnt_nxt = BLANK_LOAD;
            end
         end
         MODE_BLANK: begin
            if (w_target != r_dest) begin
               w_dest_nxt = w_target;
               if (BLANK_CYC == 1) w_state_nxt     = w_target;
               else                w_blank_cnt_nxt = BLANK_RELOAD;
            end else if (r_blank_cnt == '0) begin
               w_state_nxt = r_dest;
            end else begin
               w_blank_cnt_nxt = r_blank_cnt - BCW'(1);
            end
         end
         default: w_state_nxt = MODE_RAW;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state     <= MODE_RAW;
         r_dest      <= MODE_RAW;
         r_blank_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_dest      <= w_dest_nxt;
         r_blank_cnt <= w_blank_cnt_nxt;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_data <= '0;
      end else begin
         case (r_state)
            MODE_RAW:  r_data <= r_dly[FILT_LAT-1];
            MODE_FILT: r_data <= filt_i;
            default:   r_data <= '0;
         endcase
      end
   end

   assign w_wr = reg_if.reg_wr_i;
   assign w_rd = reg_if.reg_rd_i & ~reg_if.reg_wr_i;

   always_comb begin
      w_rd_val = '0;
      case (reg_if.reg_addr_i)
         ADDR_CTRL: begin
            w_rd_val[CTRL_MODE_REQ_BIT] = r_mode_req;
            w_rd_val[CTRL_AUTO_BYP_BIT] = r_auto_byp;
         end
         ADDR_STATUS: begin
            w_rd_val[STATUS_MODE_LSB +: 2] = r_state;
            w_rd_val[STATUS_ALARM_BIT]     = r_alarm;
         end
         ADDR_THRESH: w_rd_val = r_thresh;
         default:     w_rd_val = w_satcnt;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_mode_req <= 1'b0;
         r_auto_byp <= 1'b0;
         r_thresh   <= THRESH_RST;
         r_alarm    <= 1'b0;
         r_ack      <= 1'b0;
         r_rdata    <= '0;
      end else begin
         r_ack   <= reg_if.reg_wr_i | reg_if.reg_rd_i;
         r_rdata <= w_rd ? w_rd_val : '0;
         if (w_wr && reg_if.reg_addr_i == ADDR_CTRL) begin
            r_mode_req <= reg_if.reg_wdata_i[CTRL_MODE_REQ_BIT];
            r_auto_byp <= reg_if.reg_wdata_i[CTRL_AUTO_BYP_BIT];
         end
         if (w_wr && reg_if.reg_addr_i == ADDR_THRESH)
            r_thresh <= reg_if.reg_wdata_i;
         // Window-end set takes priority over a software clear in the same cycle.
         if (w_win_end && (w_win_total > r_thresh))
            r_alarm <= 1'b1;
         else if (w_wr && reg_if.reg_addr_i == ADDR_STATUS && reg_if.reg_wdata_i[STATUS_ALARM_BIT])
            r_alarm <= 1'b0;
      end
   end

   assign data_o             = r_data;
   assign mode_o             = r_state;
   assign alarm_o            = r_alarm;
   assign reg_if.reg_ack_o   = r_ack;
   assign reg_if.reg_rdata_o = r_rdata;

endmodule
